// File: rtl/hw_done_tracker.sv
// -----------------------------------------------------------------------------
// hw_done_tracker
//
// Start/done bookkeeping for up to four hardware engines. It sits directly
// upstream of the hardware-done PIO and drives its 8-bit in_port.
//
// Software holds a level start request per channel. A rising edge on that
// request launches the engine with a one-cycle start pulse. The channel then
// waits in BUSY for the engine's done pulse (or a watchdog timeout, when
// enabled). The result is held as sticky done/error flags until software
// drops the request. Dropping the request while BUSY aborts the channel
// without raising any flag.
//
// Optional feature macro: HW_DONE_TIMEOUT_EN
//   defined   : per-channel watchdog counters, timeout raises done+error.
//   undefined : no counters; BUSY waits for engine_done or abort only,
//               error bits of done_status read 0, TIMEOUT_CYCLES unused.
//
// Parameters:
//   NUM_CH          number of engine channels, 1..4
//   TIMEOUT_CYCLES  BUSY cycles allowed before timeout, >= 2
//
// Ports:
//   clk           in   1       system clock (PIO domain)
//   reset         in   1       synchronous, active-high reset
//   start_req     in   NUM_CH  level start request per channel
//   engine_done   in   NUM_CH  one-cycle done pulse per channel
//   engine_start  out  NUM_CH  one-cycle start pulse per channel
//   busy          out  NUM_CH  channel is in BUSY
//   done_status   out  8       [NUM_CH-1:0] done flags,
//                              [4+NUM_CH-1:4] error flags, other bits 0
// -----------------------------------------------------------------------------
module hw_done_tracker #(
   parameter int NUM_CH         = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] start_req,
   input  logic [NUM_CH-1:0] engine_done,
   output logic [NUM_CH-1:0] engine_start,
   output logic [NUM_CH-1:0] busy,
   output logic [7:0]        done_status
);

   // Elaboration-time parameter sanity checks.
   if ((NUM_CH < 1) || (NUM_CH > 4)) begin : g_bad_num_ch
      $error("hw_done_tracker: NUM_CH must be in 1..4");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("hw_done_tracker: TIMEOUT_CYCLES must be at least 2");
   end

`ifdef HW_DONE_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   logic [NUM_CH-1:0] r_start_q;
   logic [NUM_CH-1:0] w_rise;
   logic [NUM_CH-1:0] w_fall;
   logic [NUM_CH-1:0] w_done_vec;
   logic [NUM_CH-1:0] w_err_vec;
   logic [NUM_CH-1:0] w_start_vec;
   logic [NUM_CH-1:0] w_busy_vec;

   // Start request edge detection, shared by all channels.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_start_q <= '0;
      end else begin
         r_start_q <= start_req;
      end
   end

   assign w_rise = start_req & ~r_start_q;
   assign w_fall = ~start_req & r_start_q;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      state_t r_state;
      state_t w_state_nxt;
      logic   r_start;
      logic   w_start_nxt;
      logic   r_busy;
      logic   w_busy_nxt;
      logic   r_done;
      logic   w_done_nxt;
`ifdef HW_DONE_TIMEOUT_EN
      logic             r_err;
      logic             w_err_nxt;
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] w_cnt_nxt;
`endif

      // Next-state and next-output logic. Every output is a flop, so this
      // block computes the value each output takes after the coming edge.
      always_comb begin
         w_state_nxt = r_state;
         w_start_nxt = 1'b0;
         w_busy_nxt  = r_busy;
         w_done_nxt  = r_done;
`ifdef HW_DONE_TIMEOUT_EN
         w_err_nxt   = r_err;
         w_cnt_nxt   = r_cnt;
`endif
         case (r_state)
            ST_IDLE: begin
               // engine_done is meaningless here and is ignored.
               if (w_rise[g]) begin
                  w_state_nxt = ST_BUSY;
                  w_start_nxt = 1'b1;
                  w_busy_nxt  = 1'b1;
                  w_done_nxt  = 1'b0;
`ifdef HW_DONE_TIMEOUT_EN
                  w_err_nxt   = 1'b0;
                  w_cnt_nxt   = '0;
`endif
               end
            end

            ST_BUSY: begin
               // Priority: abort, then engine done, then timeout.
               if (w_fall[g]) begin
                  w_state_nxt = ST_IDLE;
                  w_busy_nxt  = 1'b0;
                  w_done_nxt  = 1'b0;
`ifdef HW_DONE_TIMEOUT_EN
                  w_err_nxt   = 1'b0;
`endif
               end else if (engine_done[g]) begin
                  w_state_nxt = ST_DONE;
                  w_busy_nxt  = 1'b0;
                  w_done_nxt  = 1'b1;
`ifdef HW_DONE_TIMEOUT_EN
                  w_err_nxt   = 1'b0;
               end else if (r_cnt == CNT_LAST) begin
                  w_state_nxt = ST_DONE;
                  w_busy_nxt  = 1'b0;
                  w_done_nxt  = 1'b1;
                  w_err_nxt   = 1'b1;
               end else begin
                  // Cannot wrap: the last value is caught by the branch above.
                  w_cnt_nxt   = r_cnt + 1'b1;
`endif
               end
            end

            ST_DONE: begin
               // Flags are sticky until software drops the request.
               if (w_fall[g]) begin
                  w_state_nxt = ST_IDLE;
                  w_done_nxt  = 1'b0;
`ifdef HW_DONE_TIMEOUT_EN
                  w_err_nxt   = 1'b0;
`endif
               end
            end

            default: begin
               w_state_nxt = ST_IDLE;
               w_busy_nxt  = 1'b0;
               w_done_nxt  = 1'b0;
`ifdef HW_DONE_TIMEOUT_EN
               w_err_nxt   = 1'b0;
`endif
            end
         endcase
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            r_state <= ST_IDLE;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef HW_DONE_TIMEOUT_EN
            r_err   <= 1'b0;
            r_cnt   <= '0;
`endif
         end else begin
            r_state <= w_state_nxt;
            r_start <= w_start_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
`ifdef HW_DONE_TIMEOUT_EN
            r_err   <= w_err_nxt;
            r_cnt   <= w_cnt_nxt;
`endif
         end
      end

      assign w_start_vec[g] = r_start;
      assign w_busy_vec[g]  = r_busy;
      assign w_done_vec[g]  = r_done;
`ifdef HW_DONE_TIMEOUT_EN
      assign w_err_vec[g]   = r_err;
`else
      assign w_err_vec[g]   = 1'b0;
`endif
   end

   assign engine_start = w_start_vec;
   assign busy         = w_busy_vec;

   // Pack flags into the PIO word; unused channel positions read 0.
   always_comb begin
      done_status                = 8'h00;
      done_status[NUM_CH-1:0]    = w_done_vec;
      done_status[4 +: NUM_CH]   = w_err_vec;
   end

endmodule

// File: tb/tb_hw_done_tracker.sv
// -----------------------------------------------------------------------------
// tb_hw_done_tracker
//
// Scoreboard bench for hw_done_tracker (NUM_CH=4, TIMEOUT_CYCLES=16).
// The stimulus process drives inputs on the falling edge, advances a
// behavioural model of the channel rules and queues the outputs expected
// after the next rising edge. A separate monitor pops one entry per rising
// edge and compares engine_start, busy and done_status.
// Watchdog expectations follow HW_DONE_TIMEOUT_EN, like the design.
// -----------------------------------------------------------------------------
module tb_hw_done_tracker;

   localparam int NUM_CH  = 4;
   localparam int TIMEOUT = 16;
`ifdef HW_DONE_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [NUM_CH-1:0] start_req = '0;
   logic [NUM_CH-1:0] engine_done = '0;
   logic [NUM_CH-1:0] engine_start;
   logic [NUM_CH-1:0] busy;
   logic [7:0]        done_status;

   hw_done_tracker #(
      .NUM_CH         (NUM_CH),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start_req    (start_req),
      .engine_done  (engine_done),
      .engine_start (engine_start),
      .busy         (busy),
      .done_status  (done_status)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [NUM_CH-1:0] st;
      logic [NUM_CH-1:0] bsy;
      logic [7:0]        ds;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Behavioural model: a channel is either running a job (started at some
   // cycle), holding a finished result, or free.
   int unsigned       cyc = 0;
   logic [NUM_CH-1:0] m_prev_req = '0;
   bit                m_run [NUM_CH];
   int unsigned       m_t0  [NUM_CH];
   bit                m_dn  [NUM_CH];
   bit                m_er  [NUM_CH];

   task automatic step(input bit r, input logic [NUM_CH-1:0] rq,
                       input logic [NUM_CH-1:0] dn);
      exp_t e;
      @(negedge clk);
      reset       = r;
      start_req   = rq;
      engine_done = dn;
      e = '0;
      if (r) begin
         for (int i = 0; i < NUM_CH; i++) begin
            m_run[i] = 1'b0;
            m_dn[i]  = 1'b0;
            m_er[i]  = 1'b0;
         end
         m_prev_req = '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            bit rise;
            bit fall;
            rise = rq[i] && !m_prev_req[i];
            fall = !rq[i] && m_prev_req[i];
            if (m_run[i]) begin
               if (fall) begin
                  m_run[i] = 1'b0;
               end else if (dn[i]) begin
                  m_run[i] = 1'b0;
                  m_dn[i]  = 1'b1;
                  m_er[i]  = 1'b0;
               end else if (TO_EN && ((cyc - m_t0[i]) == TIMEOUT)) begin
                  m_run[i] = 1'b0;
                  m_dn[i]  = 1'b1;
                  m_er[i]  = 1'b1;
               end
            end else if (m_dn[i]) begin
               if (fall) begin
                  m_dn[i] = 1'b0;
                  m_er[i] = 1'b0;
               end
            end else if (rise) begin
               m_run[i] = 1'b1;
               m_t0[i]  = cyc;
               e.st[i]  = 1'b1;
            end
         end
         m_prev_req = rq;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         e.bsy[i]    = m_run[i];
         e.ds[i]     = m_dn[i];
         e.ds[4 + i] = m_er[i];
      end
      exp_q.push_back(e);
      cyc++;
   endtask

   task automatic idle_steps(input int n, input logic [NUM_CH-1:0] rq);
      for (int k = 0; k < n; k++) step(1'b0, rq, '0);
   endtask

   // Monitor: one expected entry per rising edge, sampled 1 time unit later.
   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (engine_start !== e.st) begin
            errors++;
            $display("FAIL engine_start t=%0t got %b want %b", $time, engine_start, e.st);
         end
         checks++;
         if (busy !== e.bsy) begin
            errors++;
            $display("FAIL busy t=%0t got %b want %b", $time, busy, e.bsy);
         end
         checks++;
         if (done_status !== e.ds) begin
            errors++;
            $display("FAIL done_status t=%0t got %h want %h", $time, done_status, e.ds);
         end
      end
   end

   initial begin
      logic [NUM_CH-1:0] rq;
      logic [NUM_CH-1:0] dn;
      bit                r;

      // Reset state.
      step(1'b1, 4'b0000, 4'b0000);
      step(1'b1, 4'b0000, 4'b0000);

      // Normal done on ch0: done pulse 5 cycles after the start pulse.
      step(1'b0, 4'b0001, 4'b0000);
      idle_steps(5, 4'b0001);
      step(1'b0, 4'b0001, 4'b0001);
      idle_steps(2, 4'b0001);
      idle_steps(3, 4'b0000);

      // Reset mid-BUSY on ch0, then a stray done pulse must be ignored.
      step(1'b0, 4'b0001, 4'b0000);
      idle_steps(3, 4'b0001);
      step(1'b1, 4'b0000, 4'b0000);
      step(1'b1, 4'b0000, 4'b0000);
      idle_steps(2, 4'b0000);
      step(1'b0, 4'b0000, 4'b0001);
      idle_steps(2, 4'b0000);

      // Timeout on ch2 (or endless BUSY without the watchdog).
      step(1'b0, 4'b0100, 4'b0000);
      idle_steps(TIMEOUT + 4, 4'b0100);
      idle_steps(3, 4'b0000);

      // Done and timeout on the same edge for ch1: done wins.
      step(1'b0, 4'b0010, 4'b0000);
      idle_steps(TIMEOUT - 1, 4'b0010);
      step(1'b0, 4'b0010, 4'b0010);
      idle_steps(3, 4'b0010);
      idle_steps(2, 4'b0000);

      // Abort on ch3, late done pulse is ignored.
      step(1'b0, 4'b1000, 4'b0000);
      idle_steps(2, 4'b1000);
      step(1'b0, 4'b0000, 4'b0000);
      step(1'b0, 4'b0000, 4'b0000);
      step(1'b0, 4'b0000, 4'b1000);
      idle_steps(3, 4'b0000);

      // Concurrent ch0/ch1: done ch1 at +3, ch0 at +7.
      step(1'b0, 4'b0011, 4'b0000);
      idle_steps(2, 4'b0011);
      step(1'b0, 4'b0011, 4'b0010);
      idle_steps(3, 4'b0011);
      step(1'b0, 4'b0011, 4'b0001);
      idle_steps(2, 4'b0011);
      idle_steps(3, 4'b0000);

      // Randomized traffic on all channels.
      rq = '0;
      for (int k = 0; k < 600; k++) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if ($urandom_range(0, 7) == 0) rq[i] = ~rq[i];
            dn[i] = ($urandom_range(0, 5) == 0);
         end
         r = ($urandom_range(0, 149) == 0);
         step(r, rq, dn);
      end
      idle_steps(4, 4'b0000);

      // Drain the scoreboard with a bounded wait.
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
         @(posedge clk);
         #2;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d want 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
